cache_arbiter: RTL

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter_pkg.sv | 28 ++
 rtl/cache_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types for the icache/dcache to pmem arbiter
// Purpose: FSM state, requester identity and memory-op encodings, plus the
//          round-robin tie-break helper used by cache_arbiter.
// Ports:   none (package).
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } requester_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // On a tie the requester that did not win last time is granted.
  function automatic requester_t rr_pick(input requester_t last_grant);
    return (last_grant == INST) ? DATA : INST;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one pmem port between icache and dcache
// Purpose: grants one cache at a time to physical memory, latches the winning
//          request on the grant edge and forwards the completion pulse back.
// Ports:   clk, rst (sync, active-low)
//          icache : inst_mem_read/address in, inst_mem_rdata/resp out
//          dcache : data_mem_read/write/address/wdata in, data_mem_rdata/resp out
//          pmem   : pmem_read/write/address/wdata out, pmem_rdata/resp in
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  inst_mem_read,
  input  logic [ADDR_WIDTH-1:0] inst_mem_address,
  output logic [LINE_WIDTH-1:0] inst_mem_rdata,
  output logic                  inst_mem_resp,

  input  logic                  data_mem_read,
  input  logic                  data_mem_write,
  input  logic [ADDR_WIDTH-1:0] data_mem_address,
  input  logic [LINE_WIDTH-1:0] data_mem_wdata,
  output logic [LINE_WIDTH-1:0] data_mem_rdata,
  output logic                  data_mem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state_q, state_d;
  requester_t            last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  mem_op_t               op_q, op_d;

  always_comb begin
    logic       inst_req;
    logic       data_req;
    requester_t grant;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    inst_req     = inst_mem_read;
    data_req     = data_mem_read | data_mem_write;
    grant        = INST;

    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          if (inst_req && data_req) begin
            grant = rr_pick(last_grant_q);
          end else if (data_req) begin
            grant = DATA;
          end else begin
            grant = INST;
          end

          if (grant == DATA) begin
            state_d = SERVE_D;
            addr_d  = data_mem_address;
            wdata_d = data_mem_wdata;
            // A simultaneous read is left pending and picked up later.
            op_d    = data_mem_write ? OP_WRITE : OP_READ;
          end else begin
            state_d = SERVE_I;
            addr_d  = inst_mem_address;
            op_d    = OP_READ;
          end
        end
      end

      // Leaving on pmem_resp always passes through IDLE, which gives the
      // mandatory dead cycle on the pmem request lines.
      SERVE_I: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = INST;
        end
      end

      SERVE_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = DATA;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= INST;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= OP_READ;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
    end
  end

  // pmem side only ever sees the latched request, so cache-side changes
  // during a transaction cannot disturb it.
  assign pmem_read    = (state_q == SERVE_I) || ((state_q == SERVE_D) && (op_q == OP_READ));
  assign pmem_write   = (state_q == SERVE_D) && (op_q == OP_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign inst_mem_resp  = pmem_resp && (state_q == SERVE_I);
  assign data_mem_resp  = pmem_resp && (state_q == SERVE_D);
  assign inst_mem_rdata = pmem_rdata;
  assign data_mem_rdata = pmem_rdata;

endmodule
